// File: rtl/seg_scan_reader.sv
// ---------------------------------------------------------------------------
// seg_scan_reader
//   Reader side of a multiplexed 7-segment digit bus. The anode-select and
//   segment lines are synchronized, filtered for stability, reverse-decoded
//   to a 5-bit signed digit value and emitted as per-digit captures on a
//   valid/ready port. A full-frame snapshot is published once every digit
//   has been captured.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | anodes not one-hot, nothing being tracked
//   TRACK | one-hot pattern latched as ref, counting identical samples
//   HELD  | current stable window already captured, waiting for change
//
// Ports
//   clk           single clock
//   rst           synchronous reset, active-high
//   an_in         anode select, active-high, asynchronous to clk
//   seg_in        segment code {A,B,C,D,E,F,G,DP}, asynchronous to clk
//   cap_valid     capture available
//   cap_ready     consumer accepts capture when cap_valid & cap_ready
//   cap_idx       digit index of capture
//   cap_value     decoded value, two's complement -16..15
//   cap_err       segment code not in table (cap_value = 0)
//   frame_values  digit i at [5i+4:5i], updated atomically at frame_valid
//   frame_valid   1-cycle pulse: every digit captured since last pulse
//   overrun       sticky: a capture was dropped due to backpressure
// ---------------------------------------------------------------------------
module seg_scan_reader #(
  parameter int N_DIGITS   = 4,
  parameter int IDX_W      = 2,
  parameter int STABLE_CYC = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_DIGITS-1:0]   an_in,
  input  logic [7:0]            seg_in,
  output logic                  cap_valid,
  input  logic                  cap_ready,
  output logic [IDX_W-1:0]      cap_idx,
  output logic [4:0]            cap_value,
  output logic                  cap_err,
  output logic [5*N_DIGITS-1:0] frame_values,
  output logic                  frame_valid,
  output logic                  overrun
);

  localparam int CNT_W = $clog2(STABLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HELD  = 2'd2
  } state_t;

  // two-stage synchronizers
  logic [N_DIGITS-1:0]   an_m, an_s;
  logic [7:0]            seg_m, seg_s;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [N_DIGITS-1:0]   ref_an;
  logic [7:0]            ref_seg;

  logic [5*N_DIGITS-1:0] shadow;
  logic [N_DIGITS-1:0]   seen;
  logic [N_DIGITS-1:0]   seen_nxt;

  logic                  an_onehot;
  logic                  pat_same;
  logic [IDX_W-1:0]      ref_idx;
  logic [4:0]            dec_value;
  logic                  dec_err;
  logic                  capture;
  logic                  load;
  logic                  frame_due;

  assign an_onehot = $onehot(an_s);
  assign pat_same  = ({an_s, seg_s} == {ref_an, ref_seg});

  // The capture happens on the sample after the count has reached the
  // threshold, and only if that sample still matches the reference, so a
  // pattern that breaks at the last moment is never reported.
  assign capture   = (state == TRACK) && an_onehot && pat_same && (cnt == CNT_LAST);

  // The output register may be refilled in the same cycle it is drained.
  assign load      = capture && (!cap_valid || cap_ready);
  assign frame_due = &seen;

  always_comb begin
    ref_idx = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (ref_an[i]) ref_idx = IDX_W'(i);
    end
  end

  // A capture landing in the frame-publish cycle starts the next frame.
  always_comb begin
    seen_nxt = frame_due ? '0 : seen;
    if (capture) seen_nxt[ref_idx] = 1'b1;
  end

  // Reverse glyph decode. Positive k uses the plain glyph; negative -k
  // adds the DP bit to glyph k and encodes as 32-k. DP alone is -16.
  always_comb begin
    dec_value = 5'd0;
    dec_err   = 1'b0;
    case (ref_seg)
      8'hFC: dec_value = 5'd0;
      8'h60: dec_value = 5'd1;
      8'hDA: dec_value = 5'd2;
      8'hF2: dec_value = 5'd3;
      8'h66: dec_value = 5'd4;
      8'hB6: dec_value = 5'd5;
      8'hBE: dec_value = 5'd6;
      8'hE0: dec_value = 5'd7;
      8'hFE: dec_value = 5'd8;
      8'hE6: dec_value = 5'd9;
      8'hEE: dec_value = 5'd10;
      8'h3E: dec_value = 5'd11;
      8'h9C: dec_value = 5'd12;
      8'h7A: dec_value = 5'd13;
      8'h9E: dec_value = 5'd14;
      8'h8E: dec_value = 5'd15;
      8'h01: dec_value = 5'd16;
      8'h61: dec_value = 5'd31;
      8'hDB: dec_value = 5'd30;
      8'hF3: dec_value = 5'd29;
      8'h67: dec_value = 5'd28;
      8'hB7: dec_value = 5'd27;
      8'hBF: dec_value = 5'd26;
      8'hE1: dec_value = 5'd25;
      8'hFF: dec_value = 5'd24;
      8'hE7: dec_value = 5'd23;
      8'hEF: dec_value = 5'd22;
      8'h3F: dec_value = 5'd21;
      8'h9D: dec_value = 5'd20;
      8'h7B: dec_value = 5'd19;
      8'h9F: dec_value = 5'd18;
      8'h8F: dec_value = 5'd17;
      default: begin
        dec_value = 5'd0;
        dec_err   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_m         <= '0;
      an_s         <= '0;
      seg_m        <= '0;
      seg_s        <= '0;
      state        <= IDLE;
      cnt          <= '0;
      ref_an       <= '0;
      ref_seg      <= '0;
      shadow       <= '0;
      seen         <= '0;
      cap_valid    <= 1'b0;
      cap_idx      <= '0;
      cap_value    <= '0;
      cap_err      <= 1'b0;
      frame_values <= '0;
      frame_valid  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      an_m  <= an_in;
      an_s  <= an_m;
      seg_m <= seg_in;
      seg_s <= seg_m;

      case (state)
        IDLE: begin
          if (an_onehot) begin
            state   <= TRACK;
            cnt     <= CNT_ONE;
            ref_an  <= an_s;
            ref_seg <= seg_s;
          end
        end
        TRACK: begin
          if (!an_onehot) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (!pat_same) begin
            cnt     <= CNT_ONE;
            ref_an  <= an_s;
            ref_seg <= seg_s;
          end else if (cnt == CNT_LAST) begin
            state <= HELD;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!pat_same) begin
            if (an_onehot) begin
              state   <= TRACK;
              cnt     <= CNT_ONE;
              ref_an  <= an_s;
              ref_seg <= seg_s;
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      if (load) begin
        cap_valid <= 1'b1;
        cap_idx   <= ref_idx;
        cap_value <= dec_value;
        cap_err   <= dec_err;
      end else if (cap_ready) begin
        cap_valid <= 1'b0;
      end

      if (capture && !load) overrun <= 1'b1;

      // shadow and seen track every capture, even a dropped one
      if (capture) shadow[5*int'(ref_idx) +: 5] <= dec_value;
      seen <= seen_nxt;

      frame_valid <= frame_due;
      if (frame_due) frame_values <= shadow;
    end
  end

endmodule

// File: tb/tb_seg_scan_reader.sv
module tb_seg_scan_reader;

  logic        clk;
  logic        rst;
  logic [3:0]  an_in;
  logic [7:0]  seg_in;
  logic        cap_valid;
  logic        cap_ready;
  logic [1:0]  cap_idx;
  logic [4:0]  cap_value;
  logic        cap_err;
  logic [19:0] frame_values;
  logic        frame_valid;
  logic        overrun;

  seg_scan_reader #(.N_DIGITS(4), .IDX_W(2), .STABLE_CYC(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .an_in        (an_in),
    .seg_in       (seg_in),
    .cap_valid    (cap_valid),
    .cap_ready    (cap_ready),
    .cap_idx      (cap_idx),
    .cap_value    (cap_value),
    .cap_err      (cap_err),
    .frame_values (frame_values),
    .frame_valid  (frame_valid),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] idx;
    logic [4:0] val;
    logic       err;
  } cap_t;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic [1:0] idx;
    logic [4:0] val;
    logic       err;
  } vec_t;

  cap_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] a, input logic [7:0] s);
    an_in  = a;
    seg_in = s;
  endtask

  task automatic expect_cap(input logic [1:0] i, input logic [4:0] v, input logic e);
    cap_t c;
    c.idx = i;
    c.val = v;
    c.err = e;
    exp_q.push_back(c);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  // scoreboard: every accepted capture must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && cap_valid && cap_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got idx %0d val %0h err %0b expected no capture at %0t",
                 cap_idx, cap_value, cap_err, $time);
      end else begin
        cap_t c;
        c = exp_q.pop_front();
        check("sb_idx", 32'(cap_idx), 32'(c.idx));
        check("sb_value", 32'(cap_value), 32'(c.val));
        check("sb_err", 32'(cap_err), 32'(c.err));
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL timeout: got no finish expected finish by 200us");
    $fatal(1, "timeout");
  end

  vec_t vecs[9];
  int   found;

  initial begin
    vecs[0] = '{an: 4'b0001, seg: 8'hE7, idx: 2'd0, val: 5'b10111, err: 1'b0};
    vecs[1] = '{an: 4'b0010, seg: 8'h01, idx: 2'd1, val: 5'b10000, err: 1'b0};
    vecs[2] = '{an: 4'b0100, seg: 8'h3F, idx: 2'd2, val: 5'b10101, err: 1'b0};
    vecs[3] = '{an: 4'b1000, seg: 8'h02, idx: 2'd3, val: 5'b00000, err: 1'b1};
    vecs[4] = '{an: 4'b0001, seg: 8'hFC, idx: 2'd0, val: 5'b00000, err: 1'b0};
    vecs[5] = '{an: 4'b0010, seg: 8'h60, idx: 2'd1, val: 5'b00001, err: 1'b0};
    vecs[6] = '{an: 4'b0100, seg: 8'h9E, idx: 2'd2, val: 5'b01110, err: 1'b0};
    vecs[7] = '{an: 4'b1000, seg: 8'hFD, idx: 2'd3, val: 5'b00000, err: 1'b1};
    vecs[8] = '{an: 4'b1000, seg: 8'hB6, idx: 2'd3, val: 5'b00101, err: 1'b0};

    rst       = 1'b1;
    an_in     = '0;
    seg_in    = '0;
    cap_ready = 1'b0;
    cyc(3);
    check("rst_valid", 32'(cap_valid), 0);
    check("rst_idx", 32'(cap_idx), 0);
    check("rst_value", 32'(cap_value), 0);
    check("rst_err", 32'(cap_err), 0);
    check("rst_frame", 32'(frame_values), 0);
    check("rst_frame_valid", 32'(frame_valid), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    cyc(2);

    // single capture latency: valid appears on the 11th edge after drive
    drive(4'b0001, 8'hDA);
    expect_cap(2'd0, 5'b00010, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      check("t1_valid_cycle", 32'(cap_valid), (i >= 11) ? 1 : 0);
    end
    check("t1_idx", 32'(cap_idx), 0);
    check("t1_value", 32'(cap_value), 32'(5'b00010));
    check("t1_err", 32'(cap_err), 0);
    cyc(8);
    check("t1_valid_held", 32'(cap_valid), 1);
    cap_ready = 1'b1;
    cyc(1);
    check("t1_valid_drop", 32'(cap_valid), 0);
    cyc(8);
    drive(4'b0000, 8'h00);
    cyc(4);

    // unstable window then settled pattern: only the last one captures
    drive(4'b0001, 8'hFC);
    cyc(6);
    drive(4'b0001, 8'h60);
    cyc(6);
    drive(4'b0001, 8'hDA);
    expect_cap(2'd0, 5'b00010, 1'b0);
    for (int i = 1; i <= 13; i++) begin
      cyc(1);
      check("t3_valid_cycle", 32'(cap_valid), (i == 11) ? 1 : 0);
    end
    drive(4'b0011, 8'h60);
    cyc(20);
    check("t3_multihot_none", 32'(cap_valid), 0);
    drive(4'b0000, 8'h00);
    cyc(4);

    // decode table
    for (int v = 0; v < 9; v++) begin
      drive(vecs[v].an, vecs[v].seg);
      expect_cap(vecs[v].idx, vecs[v].val, vecs[v].err);
      cyc(14);
      drive(4'b0000, 8'h00);
      cyc(3);
    end
    check("table_drained", 32'(exp_q.size()), 0);

    // backpressure: first capture held, second dropped, overrun sticky
    cap_ready = 1'b0;
    drive(4'b0001, 8'h60);
    expect_cap(2'd0, 5'b00001, 1'b0);
    cyc(14);
    drive(4'b0010, 8'hDA);
    cyc(14);
    check("t4_valid", 32'(cap_valid), 1);
    check("t4_idx_held", 32'(cap_idx), 0);
    check("t4_value_held", 32'(cap_value), 1);
    check("t4_overrun", 32'(overrun), 1);
    drive(4'b0000, 8'h00);
    cap_ready = 1'b1;
    cyc(2);
    check("t4_second_dropped", 32'(cap_valid), 0);
    cyc(5);
    check("t4_overrun_sticky", 32'(overrun), 1);
    pulse_rst();
    check("t4_overrun_rst", 32'(overrun), 0);
    cyc(2);

    // full frame of digits 1,2,3,4
    drive(4'b0001, 8'h60);
    expect_cap(2'd0, 5'd1, 1'b0);
    cyc(14);
    check("t5_no_early_frame", 32'(frame_valid), 0);
    drive(4'b0010, 8'hDA);
    expect_cap(2'd1, 5'd2, 1'b0);
    cyc(14);
    drive(4'b0100, 8'hF2);
    expect_cap(2'd2, 5'd3, 1'b0);
    cyc(14);
    check("t5_no_early_frame", 32'(frame_valid), 0);
    drive(4'b1000, 8'h66);
    expect_cap(2'd3, 5'd4, 1'b0);
    found = 0;
    for (int i = 1; i <= 20 && found == 0; i++) begin
      cyc(1);
      if (frame_valid) found = i;
    end
    check("t5_frame_seen", 32'(found != 0), 1);
    check("t5_frame_cycle", 32'(found), 12);
    check("t5_frame_values", 32'(frame_values), 32'(20'b00100_00011_00010_00001));
    cyc(1);
    check("t5_frame_pulse", 32'(frame_valid), 0);
    cyc(4);
    drive(4'b0000, 8'h00);
    cyc(4);

    // reset mid-window with a pending capture
    cap_ready = 1'b0;
    drive(4'b0001, 8'h66);
    cyc(14);
    check("t6_pending", 32'(cap_valid), 1);
    drive(4'b0010, 8'hB6);
    cyc(7);
    rst = 1'b1;
    cyc(1);
    check("t6_valid", 32'(cap_valid), 0);
    check("t6_idx", 32'(cap_idx), 0);
    check("t6_value", 32'(cap_value), 0);
    check("t6_frame", 32'(frame_values), 0);
    check("t6_overrun", 32'(overrun), 0);
    rst = 1'b0;
    cap_ready = 1'b1;
    expect_cap(2'd1, 5'd5, 1'b0);
    found = 0;
    for (int i = 1; i <= 20 && found == 0; i++) begin
      cyc(1);
      if (cap_valid) found = i;
    end
    check("t6_resume_cycle", 32'(found), 11);
    cyc(4);
    drive(4'b0000, 8'h00);
    cyc(4);

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
